hba_quad_multi: RTL

Second-generation HBA bus quadrature encoder peripheral.
- Decodes NUM_CH A/B encoder pairs in x4 mode into signed COUNT_WIDTH up/down counters.
- Adds atomic multi-channel snapshot, count clear, per-channel change flags, sticky illegal-transition error flags and a maskable interrupt.
- Sits on the HBA slave bus at PERIPH_ADDR, alongside the other motor/sensor peripherals.

---
 rtl/hba_quad_multi.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/hba_quad_multi.sv
// hba_quad_multi: HBA-bus quadrature decoder. It decodes NUM_CH x4 encoder pairs into
//    signed up/down counters, with atomic snapshot, clear, CHANGED/ERROR flags and a
//    maskable interrupt.
// Latency: a pin edge sampled at clock edge k shows in the live count after edge k+3.
//    The bus acks one cycle after select. Clear and snapshot take effect the cycle
//    after the write ack.
// Backpressure: none. Every matching transfer is acked exactly once. The slave then
//    waits for select to drop before it accepts the next transfer.
// Ports:
//    hba_clk, hba_reset      clock, synchronous active-high reset
//    hba_select/rnw/abus     transfer request, direction, {peripheral, register} address
//    hba_dbus                write data
//    hba_dbus_slave          read data (0 outside the ack cycle)
//    hba_xferack_slave       one-cycle transfer acknowledge
//    slave_interrupt         intr_en & (any CHANGED | any ERROR), registered
//    quad_enc_a/b            asynchronous encoder pins, one pair per channel
module hba_quad_multi #(
   parameter int                DBUS_WIDTH        = 8,
   parameter int                PERIPH_ADDR_WIDTH = 4,
   parameter int                REG_ADDR_WIDTH    = 8,
   parameter int                ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
   parameter int                PERIPH_ADDR       = 0,
   parameter int                NUM_CH            = 2,
   parameter int                COUNT_WIDTH       = 16,
   parameter logic [NUM_CH-1:0] DIR_INVERT        = '0
) (
   input  logic                  hba_clk,
   input  logic                  hba_reset,
   input  logic                  hba_rnw,
   input  logic                  hba_select,
   input  logic [ADDR_WIDTH-1:0] hba_abus,
   input  logic [DBUS_WIDTH-1:0] hba_dbus,
   output logic [DBUS_WIDTH-1:0] hba_dbus_slave,
   output logic                  hba_xferack_slave,
   output logic                  slave_interrupt,
   input  logic [NUM_CH-1:0]     quad_enc_a,
   input  logic [NUM_CH-1:0]     quad_enc_b
);

   localparam int NB        = COUNT_WIDTH / 8;
   localparam int SNAP_BASE = 4;

   typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

   // Forward Gray order on {A,B}: 00 -> 01 -> 11 -> 10 -> 00
   function automatic logic [1:0] gray_next(input logic [1:0] s);
      logic [1:0] r;
      case (s)
         2'b00:   r = 2'b01;
         2'b01:   r = 2'b11;
         2'b11:   r = 2'b10;
         default: r = 2'b00;
      endcase
      return r;
   endfunction

   // ---------------------------------------------------------------------
   // Bus FSM
   // ---------------------------------------------------------------------
   state_t state_q, state_d;
   logic   periph_hit;
   logic   wr_en;
   logic [REG_ADDR_WIDTH-1:0] reg_addr;
   logic [DBUS_WIDTH-1:0]     rdata;

   assign periph_hit = (hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH] == PERIPH_ADDR_WIDTH'(PERIPH_ADDR));
   assign reg_addr   = hba_abus[REG_ADDR_WIDTH-1:0];

   always_ff @(posedge hba_clk) begin
      if (hba_reset) state_q <= S_IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (hba_select && periph_hit) state_d = S_ACK;
         S_ACK:   state_d = S_WAIT;
         S_WAIT:  if (!hba_select) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      hba_xferack_slave = (state_q == S_ACK);
      hba_dbus_slave    = (state_q == S_ACK) ? rdata : '0;
   end

   // The write commits on the clock edge that ends the ack cycle
   assign wr_en = (state_q == S_ACK) && !hba_rnw;

   // ---------------------------------------------------------------------
   // Register state
   // ---------------------------------------------------------------------
   logic enable_q, enable_d;
   logic intr_en_q, intr_en_d;
   logic clr_q, clr_d;                // one-cycle clear strobe
   logic snp_q, snp_d;                // one-cycle snapshot strobe
   logic irq_q, irq_d;
   logic [NUM_CH-1:0] changed_q, changed_d;
   logic [NUM_CH-1:0] error_q, error_d;
   logic [NUM_CH-1:0] err_w1c;
   logic [COUNT_WIDTH-1:0] cnt_q  [NUM_CH];
   logic [COUNT_WIDTH-1:0] cnt_d  [NUM_CH];
   logic [COUNT_WIDTH-1:0] snap_q [NUM_CH];
   logic [COUNT_WIDTH-1:0] snap_d [NUM_CH];

   // Only the low bits of the write data are decoded; the rest are don't-care
   logic unused_dbus;
   assign unused_dbus = ^hba_dbus;

   // ---------------------------------------------------------------------
   // Synchroniser and step decode
   // ---------------------------------------------------------------------
   logic [NUM_CH-1:0] a_s1_q, a_s2_q, b_s1_q, b_s2_q, a_prv_q, b_prv_q;
   logic [NUM_CH-1:0] up_d, dn_d, bad_d;
   logic [NUM_CH-1:0] up_q, dn_q, bad_q;
   logic [NUM_CH-1:0] step_en;

   for (genvar n = 0; n < NUM_CH; n++) begin : g_dec
      logic [1:0] cur, prv;
      logic       fwd, rev;
      assign cur      = {a_s2_q[n], b_s2_q[n]};
      assign prv      = {a_prv_q[n], b_prv_q[n]};
      assign fwd      = (cur == gray_next(prv));
      assign rev      = (prv == gray_next(cur));
      assign up_d[n]  = DIR_INVERT[n] ? rev : fwd;
      assign dn_d[n]  = DIR_INVERT[n] ? fwd : rev;
      assign bad_d[n] = (cur == ~prv);
   end

   // The sync chain and previous state run regardless of enable, so a channel
   // re-enabled after moving does not take a spurious step.
   always_ff @(posedge hba_clk) begin
      if (hba_reset) begin
         a_s1_q  <= '0;
         a_s2_q  <= '0;
         b_s1_q  <= '0;
         b_s2_q  <= '0;
         a_prv_q <= '0;
         b_prv_q <= '0;
         up_q    <= '0;
         dn_q    <= '0;
         bad_q   <= '0;
      end else begin
         a_s1_q  <= quad_enc_a;
         a_s2_q  <= a_s1_q;
         b_s1_q  <= quad_enc_b;
         b_s2_q  <= b_s1_q;
         a_prv_q <= a_s2_q;
         b_prv_q <= b_s2_q;
         up_q    <= up_d;
         dn_q    <= dn_d;
         bad_q   <= bad_d;
      end
   end

   // ---------------------------------------------------------------------
   // Control register writes
   // ---------------------------------------------------------------------
   always_comb begin
      enable_d  = enable_q;
      intr_en_d = intr_en_q;
      clr_d     = 1'b0;
      snp_d     = 1'b0;
      err_w1c   = '0;
      if (wr_en) begin
         case (reg_addr)
            REG_ADDR_WIDTH'(0): begin
               enable_d  = hba_dbus[0];
               intr_en_d = hba_dbus[1];
               clr_d     = hba_dbus[2];
               snp_d     = hba_dbus[3];
            end
            REG_ADDR_WIDTH'(2): err_w1c = hba_dbus[NUM_CH-1:0];
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Counters, snapshot, flags
   // ---------------------------------------------------------------------
   assign step_en = enable_q ? (up_q | dn_q) : '0;

   always_comb begin
      for (int n = 0; n < NUM_CH; n++) begin
         cnt_d[n] = cnt_q[n];
         if (clr_q)
            cnt_d[n] = '0;                      // clear beats a same-cycle step
         else if (enable_q && up_q[n])
            cnt_d[n] = cnt_q[n] + COUNT_WIDTH'(1);
         else if (enable_q && dn_q[n])
            cnt_d[n] = cnt_q[n] - COUNT_WIDTH'(1);
         // Snapshot takes the pre-step, pre-clear value
         snap_d[n] = snp_q ? cnt_q[n] : snap_q[n];
      end
      // A same-cycle step re-arms CHANGED over the clear/snapshot
      changed_d = ((clr_q || snp_q) ? '0 : changed_q) | step_en;
      // A same-cycle new error survives the W1C
      error_d   = (error_q & ~err_w1c) | bad_q;
      irq_d     = intr_en_q && ((|changed_q) || (|error_q));
   end

   always_ff @(posedge hba_clk) begin
      if (hba_reset) begin
         enable_q  <= 1'b0;
         intr_en_q <= 1'b0;
         clr_q     <= 1'b0;
         snp_q     <= 1'b0;
         irq_q     <= 1'b0;
         changed_q <= '0;
         error_q   <= '0;
         for (int n = 0; n < NUM_CH; n++) begin
            cnt_q[n]  <= '0;
            snap_q[n] <= '0;
         end
      end else begin
         enable_q  <= enable_d;
         intr_en_q <= intr_en_d;
         clr_q     <= clr_d;
         snp_q     <= snp_d;
         irq_q     <= irq_d;
         changed_q <= changed_d;
         error_q   <= error_d;
         for (int n = 0; n < NUM_CH; n++) begin
            cnt_q[n]  <= cnt_d[n];
            snap_q[n] <= snap_d[n];
         end
      end
   end

   assign slave_interrupt = irq_q;

   // ---------------------------------------------------------------------
   // Read mux
   // ---------------------------------------------------------------------
   always_comb begin
      rdata = '0;
      case (reg_addr)
         REG_ADDR_WIDTH'(0): rdata = {6'b0, intr_en_q, enable_q};
         REG_ADDR_WIDTH'(1): rdata[NUM_CH-1:0] = changed_q;
         REG_ADDR_WIDTH'(2): rdata[NUM_CH-1:0] = error_q;
         default: ;
      endcase
      for (int n = 0; n < NUM_CH; n++) begin
         for (int k = 0; k < NB; k++) begin
            if (reg_addr == REG_ADDR_WIDTH'(SNAP_BASE + n*NB + k))
               rdata = snap_q[n][k*8 +: 8];
         end
      end
   end

endmodule
